// File: rtl/y86_cc_cond_stage.sv
// Y86 execute-stage back end: condition-code register, jXX/cmovXX condition evaluation and E->M pipeline register.
// Optional branch statistics counters are enabled with `define COND_STATS_EN.
module y86_cc_cond_stage #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    e_valid,
  input  logic [3:0]              e_icode,
  input  logic [3:0]              e_ifun,
  input  logic [3:0]              e_dste,
  input  logic                    set_cc,
  input  logic                    cc_block,
  input  logic signed [WIDTH-1:0] alu_out,
  input  logic                    alu_ovf,
  input  logic                    m_stall,
  input  logic                    m_bubble,
  output logic                    e_cnd,
  output logic                    cc_zf,
  output logic                    cc_sf,
  output logic                    cc_of,
  output logic                    m_valid,
  output logic [3:0]              m_icode,
  output logic                    m_cnd,
  output logic [WIDTH-1:0]        m_vale,
  output logic [3:0]              m_dste
`ifdef COND_STATS_EN
  ,
  output logic [CNT_W-1:0]        taken_cnt,
  output logic [CNT_W-1:0]        nottaken_cnt
`endif
);

  localparam logic [3:0] ICODE_NOP  = 4'h1;
  localparam logic [3:0] ICODE_CMOV = 4'h2;
  localparam logic [3:0] ICODE_JXX  = 4'h7;
  localparam logic [3:0] RNONE      = 4'hF;

  function automatic logic cond_eval(input logic [3:0] ifun, input logic zf,
                                     input logic sf, input logic of);
    logic lt;
    lt = sf ^ of;
    case (ifun)
      4'd0:    cond_eval = 1'b1;
      4'd1:    cond_eval = lt | zf;
      4'd2:    cond_eval = lt;
      4'd3:    cond_eval = zf;
      4'd4:    cond_eval = ~zf;
      4'd5:    cond_eval = ~lt;
      4'd6:    cond_eval = ~lt & ~zf;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  logic             cc_zf_q, cc_sf_q, cc_of_q;
  logic             cc_zf_d, cc_sf_d, cc_of_d;
  logic             m_valid_q, m_valid_d;
  logic [3:0]       m_icode_q, m_icode_d;
  logic             m_cnd_q, m_cnd_d;
  logic [WIDTH-1:0] m_vale_q, m_vale_d;
  logic [3:0]       m_dste_q, m_dste_d;
  logic             cc_write;
  logic             m_load;
  logic             cnd;

  assign cnd = cond_eval(e_ifun, cc_zf_q, cc_sf_q, cc_of_q);

  always_comb begin
    // A stalled stage must not commit flags, even if a bubble is also requested.
    cc_write = e_valid & set_cc & ~cc_block & ~m_stall;
    m_load   = ~m_bubble & ~m_stall;
    cc_zf_d  = cc_zf_q;
    cc_sf_d  = cc_sf_q;
    cc_of_d  = cc_of_q;
    if (cc_write) begin
      cc_zf_d = (alu_out == '0);
      cc_sf_d = alu_out[WIDTH-1];
      cc_of_d = alu_ovf;
    end
  end

  always_comb begin
    m_valid_d = m_valid_q;
    m_icode_d = m_icode_q;
    m_cnd_d   = m_cnd_q;
    m_vale_d  = m_vale_q;
    m_dste_d  = m_dste_q;
    if (m_bubble) begin
      m_valid_d = 1'b0;
      m_icode_d = ICODE_NOP;
      m_cnd_d   = 1'b0;
      m_vale_d  = '0;
      m_dste_d  = RNONE;
    end else if (!m_stall) begin
      m_valid_d = e_valid;
      m_cnd_d   = cnd;
      m_vale_d  = alu_out;
      if (e_valid) begin
        m_icode_d = e_icode;
        // A cmov whose condition fails must not write its destination.
        m_dste_d  = (e_icode == ICODE_CMOV && !cnd) ? RNONE : e_dste;
      end else begin
        m_icode_d = ICODE_NOP;
        m_dste_d  = RNONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cc_zf_q   <= 1'b1;
      cc_sf_q   <= 1'b0;
      cc_of_q   <= 1'b0;
      m_valid_q <= 1'b0;
      m_icode_q <= ICODE_NOP;
      m_cnd_q   <= 1'b0;
      m_vale_q  <= '0;
      m_dste_q  <= RNONE;
    end else begin
      cc_zf_q   <= cc_zf_d;
      cc_sf_q   <= cc_sf_d;
      cc_of_q   <= cc_of_d;
      m_valid_q <= m_valid_d;
      m_icode_q <= m_icode_d;
      m_cnd_q   <= m_cnd_d;
      m_vale_q  <= m_vale_d;
      m_dste_q  <= m_dste_d;
    end
  end

  assign e_cnd   = cnd;
  assign cc_zf   = cc_zf_q;
  assign cc_sf   = cc_sf_q;
  assign cc_of   = cc_of_q;
  assign m_valid = m_valid_q;
  assign m_icode = m_icode_q;
  assign m_cnd   = m_cnd_q;
  assign m_vale  = m_vale_q;
  assign m_dste  = m_dste_q;

`ifdef COND_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + 1'b1;
  endfunction

  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0] nottaken_cnt_q, nottaken_cnt_d;

  always_comb begin
    taken_cnt_d    = taken_cnt_q;
    nottaken_cnt_d = nottaken_cnt_q;
    if (m_load && e_valid && e_icode == ICODE_JXX) begin
      if (cnd) taken_cnt_d    = sat_inc(taken_cnt_q);
      else     nottaken_cnt_d = sat_inc(nottaken_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      taken_cnt_q    <= '0;
      nottaken_cnt_q <= '0;
    end else begin
      taken_cnt_q    <= taken_cnt_d;
      nottaken_cnt_q <= nottaken_cnt_d;
    end
  end

  assign taken_cnt    = taken_cnt_q;
  assign nottaken_cnt = nottaken_cnt_q;
`else
  logic unused_load;
  assign unused_load = m_load;
`endif

endmodule

// File: tb/tb_y86_cc_cond_stage.sv
// Directed bench for y86_cc_cond_stage with a reference model feeding an expected-value queue.
// Statistics checks are included when COND_STATS_EN is defined.
module tb_y86_cc_cond_stage;

  logic        clk = 1'b0;
  logic        rst_n, e_valid, set_cc, cc_block, alu_ovf, m_stall, m_bubble;
  logic [3:0]  e_icode, e_ifun, e_dste;
  logic signed [63:0] alu_out;
  logic        e_cnd, cc_zf, cc_sf, cc_of, m_valid, m_cnd;
  logic [3:0]  m_icode, m_dste;
  logic [63:0] m_vale;

  always #5 clk = ~clk;

`ifdef COND_STATS_EN
  logic [31:0] taken_cnt, nottaken_cnt;
  logic [1:0]  s_taken, s_nottaken;
  logic        s_cnd, s_zf, s_sf, s_of, s_mv, s_mc;
  logic [3:0]  s_mi, s_md;
  logic [63:0] s_ve;
  y86_cc_cond_stage #(.WIDTH(64), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .e_valid(e_valid), .e_icode(e_icode), .e_ifun(e_ifun),
    .e_dste(e_dste), .set_cc(set_cc), .cc_block(cc_block), .alu_out(alu_out),
    .alu_ovf(alu_ovf), .m_stall(m_stall), .m_bubble(m_bubble), .e_cnd(s_cnd),
    .cc_zf(s_zf), .cc_sf(s_sf), .cc_of(s_of), .m_valid(s_mv), .m_icode(s_mi),
    .m_cnd(s_mc), .m_vale(s_ve), .m_dste(s_md), .taken_cnt(s_taken),
    .nottaken_cnt(s_nottaken));
`endif

  y86_cc_cond_stage #(.WIDTH(64), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .e_valid(e_valid), .e_icode(e_icode), .e_ifun(e_ifun),
    .e_dste(e_dste), .set_cc(set_cc), .cc_block(cc_block), .alu_out(alu_out),
    .alu_ovf(alu_ovf), .m_stall(m_stall), .m_bubble(m_bubble), .e_cnd(e_cnd),
    .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of), .m_valid(m_valid), .m_icode(m_icode),
    .m_cnd(m_cnd), .m_vale(m_vale), .m_dste(m_dste)
`ifdef COND_STATS_EN
    , .taken_cnt(taken_cnt), .nottaken_cnt(nottaken_cnt)
`endif
  );

  typedef struct packed {
    logic        zf, sf, of, v;
    logic [3:0]  ic;
    logic        cnd;
    logic [63:0] vale;
    logic [3:0]  dste;
    logic [31:0] tk, ntk;
    logic [1:0]  stk;
  } exp_t;

  exp_t   sb[$];
  exp_t   mdl;
  int     checks = 0;
  int     failures = 0;
  bit     cc_known = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic ref_cond(input logic [3:0] f, input logic z, input logic s, input logic o);
    case (f)
      4'd0: return 1'b1;
      4'd1: return (s != o) || z;
      4'd2: return s != o;
      4'd3: return z;
      4'd4: return !z;
      4'd5: return s == o;
      4'd6: return (s == o) && !z;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step(input string tag, input logic rn, input logic ev, input logic [3:0] ic,
                      input logic [3:0] fn, input logic [3:0] ds, input logic sc, input logic cb,
                      input logic [63:0] alu, input logic ovf, input logic st, input logic bb);
    logic c;
    exp_t e;
    @(negedge clk);
    rst_n = rn; e_valid = ev; e_icode = ic; e_ifun = fn; e_dste = ds; set_cc = sc;
    cc_block = cb; alu_out = alu; alu_ovf = ovf; m_stall = st; m_bubble = bb;
    #1;
    c = ref_cond(fn, mdl.zf, mdl.sf, mdl.of);
    if (cc_known) chk({tag, ".e_cnd"}, {63'd0, e_cnd}, {63'd0, c});
    if (!rn) begin
      mdl = '0; mdl.zf = 1'b1; mdl.ic = 4'h1; mdl.dste = 4'hF;
    end else begin
      if (ev && sc && !cb && !st) begin
        mdl.zf = (alu == 64'd0); mdl.sf = alu[63]; mdl.of = ovf;
      end
      if (bb) begin
        mdl.v = 1'b0; mdl.ic = 4'h1; mdl.cnd = 1'b0; mdl.vale = 64'd0; mdl.dste = 4'hF;
      end else if (!st) begin
        mdl.v = ev; mdl.cnd = c; mdl.vale = alu;
        mdl.ic = ev ? ic : 4'h1;
        mdl.dste = !ev ? 4'hF : ((ic == 4'h2 && !c) ? 4'hF : ds);
        if (ev && ic == 4'h7) begin
          if (c) begin
            mdl.tk = mdl.tk + 1;
            if (mdl.stk != 2'b11) mdl.stk = mdl.stk + 1;
          end else mdl.ntk = mdl.ntk + 1;
        end
      end
    end
    sb.push_back(mdl);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".zf"}, {63'd0, cc_zf}, {63'd0, e.zf});
    chk({tag, ".sf"}, {63'd0, cc_sf}, {63'd0, e.sf});
    chk({tag, ".of"}, {63'd0, cc_of}, {63'd0, e.of});
    chk({tag, ".m_valid"}, {63'd0, m_valid}, {63'd0, e.v});
    chk({tag, ".m_icode"}, {60'd0, m_icode}, {60'd0, e.ic});
    chk({tag, ".m_cnd"}, {63'd0, m_cnd}, {63'd0, e.cnd});
    chk({tag, ".m_vale"}, m_vale, e.vale);
    chk({tag, ".m_dste"}, {60'd0, m_dste}, {60'd0, e.dste});
`ifdef COND_STATS_EN
    chk({tag, ".taken"}, {32'd0, taken_cnt}, {32'd0, e.tk});
    chk({tag, ".nottaken"}, {32'd0, nottaken_cnt}, {32'd0, e.ntk});
    chk({tag, ".sat_taken"}, {62'd0, s_taken}, {62'd0, e.stk});
`endif
    if (!rn) cc_known = 1;
  endtask

  initial begin
    mdl = '0;
    rst_n = 1'b0; e_valid = 1'b0; e_icode = 4'h1; e_ifun = 4'h0; e_dste = 4'hF;
    set_cc = 1'b0; cc_block = 1'b0; alu_out = '0; alu_ovf = 1'b0; m_stall = 1'b0; m_bubble = 1'b0;

    // Reset with noisy inputs.
    step("rst", 0, 1, 4'h6, 4'h0, 4'h5, 1, 0, 64'h1234, 1, 0, 0);
    chk("rst.zf_const", {63'd0, cc_zf}, 64'd1);
    chk("rst.icode_const", {60'd0, m_icode}, 64'd1);
    chk("rst.dste_const", {60'd0, m_dste}, 64'hF);

    // OPq negative result, then jl / jg.
    step("opq_neg", 1, 1, 4'h6, 4'h1, 4'h2, 1, 0, -64'sd610, 0, 0, 0);
    chk("opq_neg.sf_const", {63'd0, cc_sf}, 64'd1);
    step("jl", 1, 1, 4'h7, 4'h2, 4'hF, 0, 0, 64'h0, 0, 0, 0);
    chk("jl.m_cnd_const", {63'd0, m_cnd}, 64'd1);
    step("jg", 1, 1, 4'h7, 4'h6, 4'hF, 0, 0, 64'h0, 0, 0, 0);
    chk("jg.m_cnd_const", {63'd0, m_cnd}, 64'd0);

    // OPq zero, then cmovne (not taken) / cmove (taken).
    step("opq_zero", 1, 1, 4'h6, 4'h1, 4'h4, 1, 0, 64'h0, 0, 0, 0);
    step("cmovne", 1, 1, 4'h2, 4'h4, 4'h3, 0, 0, 64'h77, 0, 0, 0);
    chk("cmovne.dste_const", {60'd0, m_dste}, 64'hF);
    step("cmove", 1, 1, 4'h2, 4'h3, 4'h3, 0, 0, 64'h77, 0, 0, 0);
    chk("cmove.dste_const", {60'd0, m_dste}, 64'h3);

    // Blocked CC write, then unblocked with overflow at the most negative value.
    step("blocked", 1, 1, 4'h6, 4'h0, 4'h1, 1, 1, 64'h8000_0000_0000_0000, 1, 0, 0);
    chk("blocked.zf_const", {63'd0, cc_zf}, 64'd1);
    step("ovf", 1, 1, 4'h6, 4'h0, 4'h1, 1, 0, 64'h8000_0000_0000_0000, 1, 0, 0);
    chk("ovf.of_const", {63'd0, cc_of}, 64'd1);
    chk("ovf.sf_const", {63'd0, cc_sf}, 64'd1);

    // Invalid slot loads a nop.
    step("invalid", 1, 0, 4'h6, 4'h0, 4'h5, 1, 0, 64'h0, 0, 0, 0);
    chk("invalid.icode_const", {60'd0, m_icode}, 64'd1);

    // Branch statistics: 3 taken, 2 not taken, one stalled jXX ignored.
    step("j_always", 1, 1, 4'h7, 4'h0, 4'hF, 0, 0, 64'h0, 0, 0, 0);
    step("j_e_nt", 1, 1, 4'h7, 4'h3, 4'hF, 0, 0, 64'h0, 0, 0, 0);
    step("j_ge", 1, 1, 4'h7, 4'h5, 4'hF, 0, 0, 64'h0, 0, 0, 0);
    step("j_stalled", 1, 1, 4'h7, 4'h0, 4'hF, 0, 0, 64'h0, 0, 1, 0);
    step("j_l_nt", 1, 1, 4'h7, 4'h2, 4'hF, 0, 0, 64'h0, 0, 0, 0);
    step("j_always2", 1, 1, 4'h7, 4'h0, 4'hF, 0, 0, 64'h0, 0, 0, 0);
`ifdef COND_STATS_EN
    chk("stats.taken_const", {32'd0, taken_cnt}, 64'd4);
    chk("stats.nottaken_const", {32'd0, nottaken_cnt}, 64'd3);
    step("j_sat", 1, 1, 4'h7, 4'h0, 4'hF, 0, 0, 64'h0, 0, 0, 0);
    chk("stats.sat_const", {62'd0, s_taken}, 64'd3);
`endif

    // Load a known word, then stall twice with changing inputs.
    step("pre_stall", 1, 1, 4'h6, 4'h1, 4'h6, 1, 0, 64'h5, 0, 0, 0);
    step("stall1", 1, 1, 4'h6, 4'h2, 4'h7, 1, 0, 64'h0, 1, 1, 0);
    step("stall2", 1, 1, 4'h2, 4'h4, 4'h8, 1, 0, -64'sd9, 0, 1, 0);
    chk("stall.vale_const", m_vale, 64'h5);
    chk("stall.zf_const", {63'd0, cc_zf}, 64'd0);
    // Bubble wins over stall; stall still blocks the CC write.
    step("bub_stall", 1, 1, 4'h6, 4'h0, 4'h9, 1, 0, 64'h0, 0, 1, 1);
    chk("bub_stall.valid_const", {63'd0, m_valid}, 64'd0);
    chk("bub_stall.zf_const", {63'd0, cc_zf}, 64'd0);
    step("reload", 1, 1, 4'h6, 4'h0, 4'hA, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0);
    // Plain bubble while a CC write is allowed.
    step("bubble", 1, 1, 4'h6, 4'h0, 4'hB, 1, 0, 64'h0, 0, 0, 1);
    chk("bubble.zf_const", {63'd0, cc_zf}, 64'd1);
    step("reload2", 1, 1, 4'h6, 4'h0, 4'hC, 1, 0, 64'h42, 0, 0, 0);
    // Reset during stall returns everything to reset values.
    step("rst_stall", 0, 1, 4'h6, 4'h0, 4'hD, 1, 0, 64'h99, 1, 1, 0);
    chk("rst_stall.vale_const", m_vale, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
